// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit: T0..T7 micro-steps per instruction class, plus HALT.
// Define CTRL_MEM_TIMEOUT_EN to bound memory waits (MEM_TIMEOUT cycles) and fault on expiry.
module control_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic        CON,
  input  logic        mem_ready,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        CONin,
  output logic        Read,
  output logic        Write,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        fault
);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110;
  localparam logic [4:0] OP_BR = 5'b10010, OP_JR = 5'b10100, OP_NOP = 5'b11010, OP_HALT = 5'b11011;

  state_e     state_q, state_d;
  logic       held_q, held_d;
  logic       fault_q, fault_d;
  logic [4:0] opcode;
  logic       is_alu3, is_imm, is_ldi, is_ld, is_st, is_br, is_jr, is_nop, is_halt, legal;
  logic       mem_wait, timeout;
  logic [3:0] alu_sel;
  logic       unused_instr;

  assign opcode       = Instruction[31:27];
  assign unused_instr = ^Instruction[26:0];

  assign is_alu3 = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) || (opcode == OP_OR);
  assign is_imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign is_ldi  = (opcode == OP_LDI);
  assign is_ld   = (opcode == OP_LD);
  assign is_st   = (opcode == OP_ST);
  assign is_br   = (opcode == OP_BR);
  assign is_jr   = (opcode == OP_JR);
  assign is_nop  = (opcode == OP_NOP);
  assign is_halt = (opcode == OP_HALT);
  assign legal   = is_alu3 || is_imm || is_ldi || is_ld || is_st || is_br || is_jr || is_nop || is_halt;

  assign alu_sel = (opcode == OP_SUB) ? 4'b0001 :
                   (opcode == OP_AND || opcode == OP_ANDI) ? 4'b0010 :
                   (opcode == OP_OR  || opcode == OP_ORI)  ? 4'b0011 : 4'b0000;

  // Steps that stall on mem_ready; held_q marks a repeat cycle of the same wait
  assign mem_wait = (state_q == S_T1) || (state_q == S_T6 && is_ld) || (state_q == S_T7 && is_st);

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int CW = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
  logic [CW-1:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d  = held_q ? wcnt_q : '0;
    timeout = 1'b0;
    if (mem_wait && !mem_ready) begin
      wcnt_d  = wcnt_d + CW'(1);
      timeout = (wcnt_d == CW'(MEM_TIMEOUT));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wcnt_q <= '0;
    else       wcnt_q <= wcnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_T0;
      held_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      S_T0: state_d = S_T1;
      S_T1: if (mem_ready) state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        if (!legal) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else if (is_halt)         state_d = S_HALT;
        else if (is_jr || is_nop)     state_d = S_T0;
        else                          state_d = S_T4;
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = (is_ld || is_st || is_br) ? S_T6 : S_T0;
      S_T6: begin
        if (is_ld) begin
          if (mem_ready) state_d = S_T7;
        end else if (is_st) state_d = S_T7;
        else                state_d = S_T0;
      end
      S_T7: if (!is_st || mem_ready) state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_T0;
    endcase
    if (timeout) begin
      fault_d = 1'b1;
      state_d = S_HALT;
    end
    held_d = mem_wait && (state_d == state_q);
  end

  // Strobes are masked while reset is held so no step fires until the sequencer is released
  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin} = '0;
    {MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write} = '0;
    alu_op = 4'b0000;
    if (!reset) begin
      case (state_q)
        S_T0: {PCout, MARin, IncPC, Zin} = '1;
        S_T1: begin
          {Zlowout, Read, MDRin} = '1;
          PCin = !held_q;
        end
        S_T2: {MDRout, IRin} = '1;
        S_T3: begin
          if (is_alu3 || is_imm)            {Grb, Rout, Yin} = '1;
          else if (is_ldi || is_ld || is_st) {Grb, BAout, Yin} = '1;
          else if (is_br)                   {Gra, Rout, CONin} = '1;
          else if (is_jr)                   {Gra, Rout, PCin} = '1;
        end
        S_T4: begin
          if (is_alu3) begin
            {Grc, Rout, Zin} = '1;
            alu_op = alu_sel;
          end else if (is_imm || is_ldi || is_ld || is_st) begin
            {Cout, Zin} = '1;
            alu_op = alu_sel;
          end else if (is_br) {PCout, Yin} = '1;
        end
        S_T5: begin
          if (is_alu3 || is_imm || is_ldi) {Zlowout, Gra, Rin} = '1;
          else if (is_ld || is_st)         {Zlowout, MARin} = '1;
          else if (is_br)                  {Cout, Zin} = '1;
        end
        S_T6: begin
          if (is_ld)      {Read, MDRin} = '1;
          else if (is_st) {Gra, Rout, MDRin} = '1;
          else if (is_br) {Zlowout, PCin} = {CON, CON};
        end
        S_T7: begin
          if (is_ld)      {MDRout, Gra, Rin} = '1;
          else if (is_st) Write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign run   = (state_q != S_HALT);
  assign fault = fault_q;

endmodule
